// File: rtl/yarp_pkg.sv
// Shared yarp core parameters.
// No logic; constants only.
// Not applicable.
package yarp_pkg;
    parameter int XLEN = 32;
endpackage

// File: rtl/yarp_mem_arbiter.sv
// Shares one memory port between fetch (imem, read-only) and load/store (dmem).
// Latency: request, grant and read response all pass through combinationally (0 added cycles).
// Backpressure: a stalled request is locked to its requester until memory grants it; one read in flight.
module yarp_mem_arbiter
    import yarp_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              imem_req_i,
    input  logic [XLEN-1:0]   imem_addr_i,
    output logic              imem_gnt_o,
    output logic              imem_rvalid_o,
    output logic [XLEN-1:0]   imem_rdata_o,
    input  logic              dmem_req_i,
    input  logic [XLEN-1:0]   dmem_addr_i,
    input  logic              dmem_we_i,
    input  logic [XLEN/8-1:0] dmem_be_i,
    input  logic [XLEN-1:0]   dmem_wdata_i,
    output logic              dmem_gnt_o,
    output logic              dmem_rvalid_o,
    output logic [XLEN-1:0]   dmem_rdata_o,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } state_t;

    localparam logic       SEL_I = 1'b0;
    localparam logic       SEL_D = 1'b1;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] streak_q, streak_d;
    logic       lock_q, lock_d;
    logic       lock_sel_q, lock_sel_d;

    logic       sel;
    logic       accept;
    logic       resp;

    // Pick the requester: a locked selection holds; otherwise dmem wins unless imem is starved.
    always_comb begin
        sel = SEL_D;
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (imem_req_i && (!dmem_req_i || streak_q == LIMIT)) begin
            sel = SEL_I;
        end
    end

    // Memory-side request, steered from the selected requester; fetch is always a full-word read.
    always_comb begin
        mem_req_o   = reset_n && (state_q == IDLE) && (imem_req_i || dmem_req_i);
        mem_addr_o  = imem_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = '1;
        mem_wdata_o = '0;
        if (sel == SEL_D) begin
            mem_addr_o  = dmem_addr_i;
            mem_we_o    = dmem_we_i;
            mem_be_o    = dmem_be_i;
            mem_wdata_o = dmem_wdata_i;
        end
    end

    assign accept        = mem_req_o && mem_gnt_i;
    assign imem_gnt_o    = accept && (sel == SEL_I);
    assign dmem_gnt_o    = accept && (sel == SEL_D);

    // A response only counts while a read is outstanding; stray ones in IDLE are dropped.
    assign resp          = reset_n && (state_q == WAIT_RESP) && mem_rvalid_i;
    assign imem_rvalid_o = resp && (owner_q == SEL_I);
    assign dmem_rvalid_o = resp && (owner_q == SEL_D);
    assign imem_rdata_o  = mem_rdata_i;
    assign dmem_rdata_o  = mem_rdata_i;

    // Next-state: read tracking, selection lock and the fetch starvation streak.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        streak_d   = streak_q;

        case (state_q)
            IDLE: begin
                if (mem_req_o && !mem_gnt_i) begin
                    lock_d     = 1'b1;
                    lock_sel_d = sel;
                end
                if (accept) begin
                    lock_d = 1'b0;
                    // Stores complete on grant; only reads wait for a response.
                    if (!mem_we_o) begin
                        state_d = WAIT_RESP;
                        owner_d = sel;
                    end
                end
            end
            WAIT_RESP: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!imem_req_i || (accept && sel == SEL_I)) begin
            streak_d = '0;
        end else if (accept && sel == SEL_D && streak_q != 4'hF) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // All arbiter state, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            streak_q   <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
        end
    end

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Self-checking bench for yarp_mem_arbiter: directed phases plus a response scoreboard.
// Memory responder answers reads one cycle after grant and applies stores to a small model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_yarp_mem_arbiter;
    localparam int XLEN = 32;

    logic              clk;
    logic              reset_n;
    logic              imem_req_i;
    logic [XLEN-1:0]   imem_addr_i;
    logic              imem_gnt_o;
    logic              imem_rvalid_o;
    logic [XLEN-1:0]   imem_rdata_o;
    logic              dmem_req_i;
    logic [XLEN-1:0]   dmem_addr_i;
    logic              dmem_we_i;
    logic [XLEN/8-1:0] dmem_be_i;
    logic [XLEN-1:0]   dmem_wdata_i;
    logic              dmem_gnt_o;
    logic              dmem_rvalid_o;
    logic [XLEN-1:0]   dmem_rdata_o;
    logic              mem_req_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic              mem_we_o;
    logic [XLEN/8-1:0] mem_be_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;

    logic              resp_vld;
    logic              spur_vld;
    logic              auto_resp;

    int n_checks = 0;
    int n_errors = 0;

    // Expected read responses: {port (0 imem, 1 dmem), data}.
    logic [32:0] sb[$];
    logic [31:0] mem_model [logic [31:0]];

    assign mem_rvalid_i = resp_vld | spur_vld;

    yarp_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req_i    (imem_req_i),
        .imem_addr_i   (imem_addr_i),
        .imem_gnt_o    (imem_gnt_o),
        .imem_rvalid_o (imem_rvalid_o),
        .imem_rdata_o  (imem_rdata_o),
        .dmem_req_i    (dmem_req_i),
        .dmem_addr_i   (dmem_addr_i),
        .dmem_we_i     (dmem_we_i),
        .dmem_be_i     (dmem_be_i),
        .dmem_wdata_i  (dmem_wdata_i),
        .dmem_gnt_o    (dmem_gnt_o),
        .dmem_rvalid_o (dmem_rvalid_o),
        .dmem_rdata_o  (dmem_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: read data one cycle after an accepted read, stores update the model.
    initial begin
        resp_vld    = 1'b0;
        mem_rdata_i = '0;
        forever begin
            logic        take;
            logic        we;
            logic [31:0] a;
            logic [31:0] wd;
            logic [3:0]  be;
            @(negedge clk);
            take = reset_n && mem_req_o && mem_gnt_i;
            we   = mem_we_o;
            a    = mem_addr_o;
            wd   = mem_wdata_o;
            be   = mem_be_o;
            @(posedge clk);
            #1;
            resp_vld = 1'b0;
            if (take && we) begin
                logic [31:0] old;
                old = mem_model.exists(a) ? mem_model[a] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
                mem_model[a] = old;
            end else if (take && auto_resp) begin
                resp_vld    = 1'b1;
                mem_rdata_i = mem_model.exists(a) ? mem_model[a] : 32'h0;
            end
        end
    end

    // Scoreboard: every rvalid must match the oldest expected response.
    always @(negedge clk) begin
        if (imem_rvalid_o && dmem_rvalid_o) begin
            check("rv_both", 32'd1, 32'd0);
        end else if (imem_rvalid_o || dmem_rvalid_o) begin
            if (sb.size() == 0) begin
                check("rv_unexpected", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("rv_port", {31'd0, dmem_rvalid_o}, {31'd0, e[32]});
                check("rv_data", dmem_rvalid_o ? dmem_rdata_o : imem_rdata_o, e[31:0]);
            end
        end
    end

    initial begin
        int gcount;
        int cyc;

        mem_model[32'h100] = 32'hDEADBEEF;
        mem_model[32'h200] = 32'h22222222;
        mem_model[32'h300] = 32'h0BADF00D;
        mem_model[32'h44]  = 32'h44444444;
        mem_model[32'h40]  = 32'h00000000;

        // Reset with both requesters and memory active: everything must be quiet.
        reset_n      = 1'b0;
        auto_resp    = 1'b1;
        spur_vld     = 1'b1;
        imem_req_i   = 1'b1;
        imem_addr_i  = 32'h100;
        dmem_req_i   = 1'b1;
        dmem_addr_i  = 32'h10;
        dmem_we_i    = 1'b0;
        dmem_be_i    = 4'hF;
        dmem_wdata_i = '0;
        mem_gnt_i    = 1'b1;
        @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_imem_gnt", {31'd0, imem_gnt_o}, 32'd0);
        check("rst_dmem_gnt", {31'd0, dmem_gnt_o}, 32'd0);
        check("rst_rvalids", {30'd0, imem_rvalid_o, dmem_rvalid_o}, 32'd0);
        tick();
        reset_n    = 1'b1;
        spur_vld   = 1'b0;
        imem_req_i = 1'b0;
        dmem_req_i = 1'b0;
        @(negedge clk);
        check("idle_mem_req", {31'd0, mem_req_o}, 32'd0);

        // Single fetch with immediate grant.
        tick();
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h100;
        sb.push_back({1'b0, 32'hDEADBEEF});
        @(negedge clk);
        check("fetch_gnt", {31'd0, imem_gnt_o}, 32'd1);
        check("fetch_dgnt", {31'd0, dmem_gnt_o}, 32'd0);
        check("fetch_addr", mem_addr_o, 32'h100);
        check("fetch_we_be", {27'd0, mem_we_o, mem_be_o}, 32'h0F);
        tick();
        imem_req_i = 1'b0;
        @(negedge clk);
        check("fetch_rvalid", {31'd0, imem_rvalid_o}, 32'd1);
        check("fetch_drvalid", {31'd0, dmem_rvalid_o}, 32'd0);
        tick();

        // Contention: stores from dmem against continuous fetch; imem every fifth grant.
        imem_req_i   = 1'b1;
        imem_addr_i  = 32'h300;
        dmem_req_i   = 1'b1;
        dmem_we_i    = 1'b1;
        dmem_addr_i  = 32'h10;
        dmem_wdata_i = 32'h5A5A5A5A;
        gcount = 0;
        cyc    = 0;
        while (gcount < 10 && cyc < 40) begin
            @(negedge clk);
            if (imem_gnt_o && dmem_gnt_o) check("cont_both", 32'd1, 32'd0);
            if (imem_gnt_o || dmem_gnt_o) begin
                check("cont_order", {31'd0, imem_gnt_o}, (gcount % 5 == 4) ? 32'd1 : 32'd0);
                if (imem_gnt_o) sb.push_back({1'b0, 32'h0BADF00D});
                gcount++;
            end
            tick();
            cyc++;
        end
        check("cont_grants", gcount, 32'd10);
        imem_req_i = 1'b0;
        dmem_req_i = 1'b0;
        tick();
        tick();

        // Lock: stalled fetch holds the port even after dmem arrives.
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h200;
        mem_gnt_i   = 1'b0;
        sb.push_back({1'b0, 32'h22222222});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("lock_addr", mem_addr_o, 32'h200);
            check("lock_nogrant", {30'd0, imem_gnt_o, dmem_gnt_o}, 32'd0);
            tick();
            if (c == 0) begin
                dmem_req_i  = 1'b1;
                dmem_we_i   = 1'b0;
                dmem_addr_i = 32'h44;
            end
        end
        mem_gnt_i = 1'b1;
        @(negedge clk);
        check("lock_igrant", {30'd0, imem_gnt_o, dmem_gnt_o}, 32'd2);
        check("lock_addr_g", mem_addr_o, 32'h200);
        tick();
        imem_req_i = 1'b0;
        @(negedge clk);
        check("lock_wait_req", {31'd0, mem_req_o}, 32'd0);
        tick();
        sb.push_back({1'b1, 32'h44444444});
        @(negedge clk);
        check("lock_dgrant", {30'd0, imem_gnt_o, dmem_gnt_o}, 32'd1);
        check("lock_daddr", mem_addr_o, 32'h44);
        tick();
        dmem_req_i = 1'b0;
        tick();

        // Store then load of the same word.
        dmem_req_i   = 1'b1;
        dmem_we_i    = 1'b1;
        dmem_addr_i  = 32'h40;
        dmem_be_i    = 4'b0011;
        dmem_wdata_i = 32'hABCD1234;
        @(negedge clk);
        check("st_gnt", {31'd0, dmem_gnt_o}, 32'd1);
        check("st_fields", {27'd0, mem_we_o, mem_be_o}, 32'h13);
        check("st_wdata", mem_wdata_o, 32'hABCD1234);
        tick();
        dmem_we_i = 1'b0;
        dmem_be_i = 4'hF;
        sb.push_back({1'b1, 32'h00001234});
        @(negedge clk);
        check("st_no_rvalid", {30'd0, imem_rvalid_o, dmem_rvalid_o}, 32'd0);
        check("ld_gnt", {31'd0, dmem_gnt_o}, 32'd1);
        tick();
        dmem_req_i = 1'b0;
        @(negedge clk);
        check("ld_rvalids", {30'd0, imem_rvalid_o, dmem_rvalid_o}, 32'd1);
        tick();

        // Reset while a load is outstanding, then a stray response.
        auto_resp   = 1'b0;
        dmem_req_i  = 1'b1;
        dmem_addr_i = 32'h44;
        @(negedge clk);
        check("rr_gnt", {31'd0, dmem_gnt_o}, 32'd1);
        tick();
        dmem_req_i  = 1'b0;
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h100;
        @(negedge clk);
        check("rr_wait_block", {30'd0, mem_req_o, imem_gnt_o}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rr_rst_req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        imem_req_i = 1'b0;
        auto_resp  = 1'b1;
        spur_vld   = 1'b1;
        @(negedge clk);
        check("rr_spurious", {30'd0, imem_rvalid_o, dmem_rvalid_o}, 32'd0);
        tick();
        spur_vld   = 1'b0;
        imem_req_i = 1'b1;
        sb.push_back({1'b0, 32'hDEADBEEF});
        @(negedge clk);
        check("rr_new_gnt", {31'd0, imem_gnt_o}, 32'd1);
        tick();
        imem_req_i = 1'b0;
        tick();
        tick();

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop if the stimulus ever stalls.
    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
